// File: rtl/apb_master.sv
// APB requester for two completers: accepts one command at a time, runs SETUP/ACCESS,
// and reports completion on a one-cycle response strobe with a bounded wait time.
module apb_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELECT1,
  output logic                  PSELECT2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic                  PSLVERR1,
  input  logic                  PSLVERR2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [7:0]            cnt_d;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Only the addressed completer is observed; PSELECT2 stays stable through ACCESS.
  assign sel_ready = PSELECT2 ? PREADY2  : PREADY1;
  assign sel_err   = PSELECT2 ? PSLVERR2 : PSLVERR1;
  assign sel_rdata = PSELECT2 ? PRDATA2  : PRDATA1;
  assign cnt_d     = cnt_q + 8'd1;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSELECT1  <= 1'b0;
      PSELECT2  <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          // cmd_ready comes up one edge after reset release, then tracks IDLE.
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr[ADDR_WIDTH-1:0];
            PWDATA    <= cmd_wdata;
            PSELECT1  <= ~cmd_addr[ADDR_WIDTH];
            PSELECT2  <= cmd_addr[ADDR_WIDTH];
            cnt_q     <= '0;
            state_q   <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready || (cnt_d >= TO)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= sel_ready ? sel_err : 1'b1;
            rsp_rdata <= (sel_ready && !PWRITE) ? sel_rdata : '0;
            PSELECT1  <= 1'b0;
            PSELECT2  <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester driving the shared APB bus toward two completers (Slave1, Slave2).
- Accepts single read/write commands from a local valid/ready command port and runs the SETUP/ACCESS sequence.
- Returns read data and error status on a one-cycle response strobe.
- Bounds completer wait states with a timeout so a hung completer cannot stall the bus.

Parameters:
ADDR_WIDTH, 7, PADDR width; the command address is ADDR_WIDTH+1 bits, with the MSB selecting the completer
DATA_WIDTH, 8, PWDATA/PRDATA width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (1..255)

Ports:
PCLK  input  1  bus clock, rising edge
PRESET  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH+1  [ADDR_WIDTH]=completer select (0→Slave1, 1→Slave2), low bits=PADDR
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and aborts)
rsp_err  output  1  PSLVERR sampled high or timeout
PSELECT1  output  1  completer 1 select
PSELECT2  output  1  completer 2 select
PENABLE  output  1  ACCESS phase
PWRITE  output  1  transfer direction
PADDR  output  ADDR_WIDTH  transfer address
PWDATA  output  DATA_WIDTH  write data
PRDATA1, PRDATA2  input  DATA_WIDTH  read data per completer
PREADY1, PREADY2  input  1  ready per completer
PSLVERR1, PSLVERR2  input  1  error per completer

Behaviour:
- Reset (PRESET low, asynchronous):
  - State to IDLE.
  - All outputs 0, including cmd_ready, PSELECTx, PENABLE, PWRITE, PADDR, PWDATA, rsp_*.
  - Wait counter cleared.
- Registered FSM with states IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1 (only when PRESET high). cmd_ready is 0 in SETUP and ACCESS.
  - On a PCLK edge with cmd_valid&cmd_ready: latch write, addr, and wdata into bus registers; go to SETUP.
- SETUP (exactly one cycle):
  - PSELECTx=1 per cmd_addr MSB, the other select 0; PENABLE=0.
  - PWRITE, PADDR, PWDATA valid.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1; select, PWRITE, PADDR, PWDATA held stable.
  - Only the selected completer's PREADY, PRDATA, and PSLVERR are sampled; the other completer's signals are ignored.
  - Selected PREADY high at an edge:
    - Transfer completes; return to IDLE.
    - Drop PSELECTx and PENABLE.
    - rsp_valid=1 for the following cycle.
    - rsp_err = sampled PSLVERR.
    - rsp_rdata = PRDATA for reads, 0 for writes.
  - Selected PREADY low: wait counter increments.
    - If the counter reaches TIMEOUT: abort, return to IDLE, drop the bus, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
- Latency:
  - Zero-wait completer: accept edge N, SETUP cycle N→N+1, ACCESS N+1→N+2, rsp_valid high N+2→N+3.
  - Each wait state adds one cycle.
- Minimum gap: one IDLE cycle between transfers. cmd_ready re-asserts in the same cycle rsp_valid is high, so the next SETUP can start one cycle after the strobe.
- rsp_valid is a strobe with no back-pressure; rsp_rdata and rsp_err hold their value until the next response.
- PADDR and PWDATA hold their last value in IDLE; no glitching between transfers.
- Wait counter:
  - 8-bit, cleared on entry to SETUP.
  - TIMEOUT=1 aborts on the first low-PREADY ACCESS cycle.
- Reset mid-transfer: bus deasserts immediately; no rsp_valid is generated for the aborted command.
- cmd_valid or cmd inputs changing while busy: ignored; latched values are unaffected.

Test Plan:
- Write cmd_addr=0x05, wdata=0xA5, Slave1 zero-wait → PSELECT1 SETUP 1 cycle, PENABLE 1 cycle, PADDR=0x05, PWDATA=0xA5, PWRITE=1; rsp_valid at N+2, rsp_err=0, rsp_rdata=0.
- Read cmd_addr=0x05 after the write → rsp_rdata=0xA5, rsp_err=0; PSELECT2 stays 0.
- Read cmd_addr=0x83 from Slave2 with PREADY2 low 3 cycles and PRDATA2=0x3C → PADDR=0x03, PSELECT2 only, ACCESS lasts 4 cycles, rsp_rdata=0x3C, signals stable throughout.
- Slave1 with PREADY1 stuck low, TIMEOUT=16 → abort after 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0, FSM back in IDLE accepting the next command.
- Slave1 completing with PSLVERR1=1 on a read → rsp_err=1, rsp_rdata=PRDATA1; meanwhile PREADY2=1 and PSLVERR2=1 have no effect.
- PRESET pulsed low during ACCESS → all outputs 0 asynchronously, no rsp_valid; a new command accepted after release completes normally. cmd_valid held high throughout → exactly one accept per IDLE.
